// File: rtl/logic_unit_arbiter_pkg.sv
// Shared opcodes, FSM states and arbitration helper for logic_unit_arbiter.
// Optional zero flag on the result is enabled with LOGIC_ARB_ZERO_FLAG_EN.
package logic_unit_arbiter_pkg;

    localparam logic [1:0] LOGIC_OP_AND = 2'b00;
    localparam logic [1:0] LOGIC_OP_OR  = 2'b01;
    localparam logic [1:0] LOGIC_OP_NOR = 2'b10;
    localparam logic [1:0] LOGIC_OP_INV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

    typedef struct packed {
        logic [1:0]  opr;
        logic [31:0] a;
        logic [31:0] b;
    } op_req_t;

    // Returns 1 when requester 1 wins. A lone request always wins; the pointer
    // only breaks ties in round-robin mode.
    function automatic logic pick_req1(input logic req0, input logic req1,
                                       input logic ptr, input logic rr_mode);
        if (req0 && req1) begin
            return rr_mode ? ptr : 1'b0;
        end
        return req1;
    endfunction

endpackage

// File: rtl/logic_unit_arbiter_op_unit.sv
// logic_op_unit_32: purely combinational 32-bit AND / OR / NOR / INV unit
// with a 4:1 opcode select.
module logic_op_unit_32
    import logic_unit_arbiter_pkg::*;
(
    input  logic [1:0]  opr,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic [31:0] and_w;
    logic [31:0] or_w;
    logic [31:0] nor_w;
    logic [31:0] inv_w;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_bit
            assign and_w[gi] = a[gi] & b[gi];
            assign or_w[gi]  = a[gi] | b[gi];
            assign nor_w[gi] = ~(a[gi] | b[gi]);
            assign inv_w[gi] = ~a[gi];
        end
    endgenerate

    always_comb begin
        y = and_w;
        case (opr)
            LOGIC_OP_AND: y = and_w;
            LOGIC_OP_OR:  y = or_w;
            LOGIC_OP_NOR: y = nor_w;
            LOGIC_OP_INV: y = inv_w;
            default:      y = and_w;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter in front of one shared 32-bit logic unit.
// Define LOGIC_ARB_ZERO_FLAG_EN to add the registered ZERO result flag.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int ARB_MODE = 1,
    parameter int INIT_PTR = 0
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ0,
    input  logic [1:0]  OPR0,
    input  logic [31:0] A0,
    input  logic [31:0] B0,
    input  logic        REQ1,
    input  logic [1:0]  OPR1,
    input  logic [31:0] A1,
    input  logic [31:0] B1,
    output logic        GNT0,
    output logic        GNT1,
    output logic        DONE0,
    output logic        DONE1,
    output logic [31:0] RESULT,
    output logic        BUSY
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    ,
    output logic        ZERO
`endif
);

    localparam logic RR_MODE = (ARB_MODE != 0);
    localparam logic PTR_RST = (INIT_PTR != 0);

    arb_state_e  state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        owner_q, owner_d;
    op_req_t     op_q, op_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        busy_q, busy_d;
    logic [31:0] result_q, result_d;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    logic        zero_q, zero_d;
`endif

    logic        win1;
    logic [31:0] unit_y;
    op_req_t     req0_op;
    op_req_t     req1_op;

    assign req0_op = '{opr: OPR0, a: A0, b: B0};
    assign req1_op = '{opr: OPR1, a: A1, b: B1};

    // The unit only ever sees latched operands, so requester-side changes
    // after the grant edge cannot disturb an operation in flight.
    logic_op_unit_32 u_op_unit (
        .opr (op_q.opr),
        .a   (op_q.a),
        .b   (op_q.b),
        .y   (unit_y)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        op_d     = op_q;
        gnt0_d   = gnt0_q;
        gnt1_d   = gnt1_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        busy_d   = busy_q;
        result_d = result_q;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        zero_d   = zero_q;
`endif
        win1     = pick_req1(REQ0, REQ1, ptr_q, RR_MODE);

        case (state_q)
            ST_IDLE: begin
                if (REQ0 || REQ1) begin
                    state_d = ST_EXEC;
                    owner_d = win1;
                    op_d    = win1 ? req1_op : req0_op;
                    gnt0_d  = !win1;
                    gnt1_d  = win1;
                    busy_d  = 1'b1;
                end
            end
            ST_EXEC: begin
                result_d = unit_y;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
                zero_d   = (unit_y == 32'h0);
`endif
                done0_d  = !owner_q;
                done1_d  = owner_q;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                // Hand priority to whoever was not just served.
                ptr_d   = !owner_q;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            ptr_q    <= PTR_RST;
            owner_q  <= 1'b0;
            op_q     <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= 32'h0;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            busy_q   <= busy_d;
            result_q <= result_d;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    assign GNT0   = gnt0_q;
    assign GNT1   = gnt1_q;
    assign DONE0  = done0_q;
    assign DONE1  = done1_q;
    assign RESULT = result_q;
    assign BUSY   = busy_q;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    assign ZERO   = zero_q;
`endif

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 32-bit combinational logic unit (AND / OR / NOR / INV) between two requesters, requester 0 and requester 1.
- Provides request/grant/done handshakes, round-robin or fixed-priority arbitration, operand latching and a registered result.
- Sits beside the ALU in the datapath so the control unit and a secondary client can issue bitwise operations without duplicating gate arrays.

Parameters:
- ARB_MODE, 1, arbitration scheme: 1 = round-robin, 0 = fixed priority with requester 0 highest.
- INIT_PTR, 0, requester given priority first after reset in round-robin mode (0 or 1).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous active-low reset.
- REQ0  input  1  requester 0 request; held high until DONE0.
- OPR0  input  2  requester 0 opcode.
- A0  input  32  requester 0 operand A.
- B0  input  32  requester 0 operand B.
- REQ1, OPR1, A1, B1  input  1/2/32/32  same as above for requester 1.
- GNT0  output  1  requester 0 owns the unit (EXEC and RESP).
- GNT1  output  1  requester 1 owns the unit.
- DONE0  output  1  one-cycle pulse: RESULT is valid for requester 0.
- DONE1  output  1  one-cycle pulse: RESULT is valid for requester 1.
- RESULT  output  32  registered result; held until the next completion.
- BUSY  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (RST=0, asynchronous):
  - FSM goes to IDLE.
  - GNT0/1, DONE0/1 and BUSY go to 0; RESULT goes to 32'h0.
  - Operand/opcode latches clear to 0; priority pointer loads INIT_PTR.
  - Reset mid-operation aborts the operation: no DONE is produced, and requesters must re-request.
- Opcodes:
  - 2'b00 AND(A,B).
  - 2'b01 OR(A,B).
  - 2'b10 NOR(A,B).
  - 2'b11 INV(A); B is ignored.
- FSM states IDLE, EXEC, RESP:
  - IDLE: if neither REQ is high, stay. Otherwise pick a winner, latch its OPR/A/B, register GNTx=1 and BUSY=1, go to EXEC.
  - EXEC: latched operands drive the logic unit. RESULT captures the unit output at the end of the cycle. Go to RESP.
  - RESP: DONEx=1 for exactly this cycle and GNTx stays 1. Update the pointer: after serving x, priority goes to the other requester. Go to IDLE; GNTx, DONEx and BUSY deassert there.
- Latency: REQ sampled high at edge N gives GNT at N+1 and DONE at N+2, with RESULT valid from N+2 onward. One operation takes 3 cycles including IDLE; peak throughput is 1 operation per 3 cycles.
- Simultaneous REQ0 and REQ1 in IDLE:
  - ARB_MODE=1: the pointer holder wins.
  - ARB_MODE=0: requester 0 always wins.
- A single request wins regardless of the pointer; the pointer still updates after service.
- Operand changes or REQ deassertion after the grant edge are ignored, because operands are latched.
- A requester must drop REQ in the cycle DONE is high. If REQ is still high in IDLE, it is treated as a new request.
- GNT0 and GNT1 are never high together; DONE0 and DONE1 are never high together.
- RESULT is unchanged in IDLE and EXEC until the capture edge.

Optional Feature:
- Macro LOGIC_ARB_ZERO_FLAG_EN.
- Defined: adds output ZERO (1 bit), registered with RESULT. ZERO=1 exactly when the captured result is 32'h0; reset value 0; held with RESULT.
- Undefined: no ZERO port and no comparator logic. All other behaviour is identical.

Decomposition:
- The 2-bit opcode encodings (`LOGIC_OP_AND/OR/NOR/INV) and the FSM state encodings go as defines in prj_definition.v.
- One combinational sub-module, logic_op_unit_32: instances the 32-bit AND, OR, NOR and inverter gate modules and a 4:1 opcode mux.
- The arbiter holds only the FSM, pointer, latches and output registers.

Test Plan:
- Reset: assert RST=0 mid-EXEC with REQ0=1 -> all outputs 0 immediately, no DONE0, FSM in IDLE after release.
- Single request: REQ0=1, OPR0=00, A0=32'hDA00006D, B0=32'hFFFFFFFF -> GNT0 one cycle later, DONE0 pulse two cycles later, RESULT=32'hDA00006D.
- Opcode sweep on requester 1 with the same operands:
  - OR -> 32'hFFFFFFFF.
  - NOR -> 32'h00000000 (ZERO=1 when the macro is defined).
  - INV -> 32'h25FFFF92.
- Contention, ARB_MODE=1, both REQ held continuously: grants alternate 0,1,0,1; DONE pulses 3 cycles apart; GNT0 and GNT1 never overlap.
- Contention, ARB_MODE=0, both REQ held: requester 0 is granted every time and requester 1 is starved until REQ0 drops.
- Operand hold: change A0 to 32'h0 in EXEC after the grant -> RESULT reflects the originally latched A0.
